// File: rtl/neopixel_pkg.sv
// Constants, FSM states and the pixel word layout shared by the NeoPixel receive decoder and the LED chain transmitter.
// Build option NEOPIXEL_RX_RGBW_EN selects 32-bit GRBW pixels; the default build uses 24-bit GRB pixels.
package neopixel_pkg;

  // Default bit timing at the 50 MHz system clock.
  localparam int unsigned DEF_BIT1_THRESHOLD  = 30;
  localparam int unsigned DEF_MIN_HIGH_CYCLES = 8;
  localparam int unsigned DEF_MAX_HIGH_CYCLES = 60;
  localparam int unsigned DEF_RESET_CYCLES    = 2500;

  localparam int unsigned HIGH_CNT_W = 8;
  localparam int unsigned LOW_CNT_W  = 12;
  localparam int unsigned BIT_CNT_W  = 6;

`ifdef NEOPIXEL_RX_RGBW_EN
  localparam int unsigned BITS_PER_PIXEL = 32;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
    logic [7:0] w;
  } t_neopixel_pixel;
`else
  localparam int unsigned BITS_PER_PIXEL = 24;

  typedef struct packed {
    logic [7:0] pad;
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } t_neopixel_pixel;
`endif

  typedef enum logic [1:0] {
    WAIT_LATCH,
    IDLE,
    HIGH,
    LOW
  } t_neopixel_rx_state;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/neopixel_rx_sync_edge.sv
// Synchroniser for an asynchronous serial input followed by a registered rise/fall detector.
// level, rise and fall are mutually aligned and trail the pin by SYNC_STAGES+1 cycles.
module neopixel_rx_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      level  <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~level;
      fall   <= ~sync_q[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/neopixel_rx_decoder.sv
// WS2812/NeoPixel chain receiver: decodes pulse-width bits into pixels, detects latch gaps, regenerates the downstream stream.
// Build option NEOPIXEL_RX_RGBW_EN (see neopixel_pkg) switches to 32-bit GRBW pixels.
module neopixel_rx_decoder
  import neopixel_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned BIT1_THRESHOLD  = DEF_BIT1_THRESHOLD,
  parameter int unsigned MIN_HIGH_CYCLES = DEF_MIN_HIGH_CYCLES,
  parameter int unsigned MAX_HIGH_CYCLES = DEF_MAX_HIGH_CYCLES,
  parameter int unsigned RESET_CYCLES    = DEF_RESET_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        led_data_in,
  output logic        led_data_out,
  output logic        pixel_valid,
  output logic [31:0] pixel_data,
  output logic [7:0]  pixel_index,
  output logic        frame_latch,
  output logic        error
);

  logic level, rise, fall;

  neopixel_rx_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (led_data_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  t_neopixel_rx_state          state;
  logic [HIGH_CNT_W-1:0]       high_cnt;
  logic [LOW_CNT_W-1:0]        low_cnt;
  logic [BIT_CNT_W-1:0]        bit_cnt;
  logic [BITS_PER_PIXEL-1:0]   shift_q;
  logic [BITS_PER_PIXEL-1:0]   shift_next;
  t_neopixel_pixel             pixel_q;
  logic                        fwd_en;

  logic latch_hit, bit_val, bit_short, bit_long, pixel_done;

  // low_cnt only advances while the line is low, so equality fires exactly once per gap.
  assign latch_hit  = (low_cnt == LOW_CNT_W'(RESET_CYCLES));
  assign bit_val    = (high_cnt >= HIGH_CNT_W'(BIT1_THRESHOLD));
  assign bit_short  = (high_cnt <  HIGH_CNT_W'(MIN_HIGH_CYCLES));
  assign bit_long   = (high_cnt >  HIGH_CNT_W'(MAX_HIGH_CYCLES));
  assign shift_next = {shift_q[BITS_PER_PIXEL-2:0], bit_val};
  assign pixel_done = (bit_cnt == BIT_CNT_W'(BITS_PER_PIXEL - 1));
  assign pixel_data = pixel_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= WAIT_LATCH;
      high_cnt     <= '0;
      low_cnt      <= '0;
      bit_cnt      <= '0;
      shift_q      <= '0;
      pixel_q      <= '0;
      fwd_en       <= 1'b0;
      led_data_out <= 1'b0;
      pixel_valid  <= 1'b0;
      pixel_index  <= '0;
      frame_latch  <= 1'b0;
      error        <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_latch <= 1'b0;
      error       <= 1'b0;

      if (rise)
        high_cnt <= '0;
      else if (level && high_cnt != '1)
        high_cnt <= high_cnt + HIGH_CNT_W'(1);

      if (fall)
        low_cnt <= '0;
      else if (!level && low_cnt != '1)
        low_cnt <= low_cnt + LOW_CNT_W'(1);

      // fwd_en is only raised on a falling edge, so the pulse in flight is never cut in half.
      led_data_out <= fwd_en & level;

      if (pixel_valid)
        pixel_index <= sat_inc8(pixel_index);

      case (state)
        WAIT_LATCH: begin
          if (latch_hit) begin
            pixel_index <= '0;
            bit_cnt     <= '0;
            state       <= rise ? HIGH : IDLE;
          end
        end

        IDLE: begin
          if (rise)
            state <= HIGH;
        end

        HIGH: begin
          if (bit_long || (fall && bit_short)) begin
            error   <= 1'b1;
            bit_cnt <= '0;
            fwd_en  <= 1'b0;
            state   <= WAIT_LATCH;
          end else if (fall) begin
            shift_q <= shift_next;
            state   <= LOW;
            if (pixel_done) begin
              bit_cnt     <= '0;
              pixel_valid <= 1'b1;
              pixel_q     <= t_neopixel_pixel'(32'(shift_next));
              fwd_en      <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end

        LOW: begin
          // A rise coinciding with the gap still closes this frame; it opens the first bit of the next.
          if (latch_hit) begin
            frame_latch <= 1'b1;
            error       <= (bit_cnt != '0);
            pixel_index <= '0;
            bit_cnt     <= '0;
            fwd_en      <= 1'b0;
            state       <= rise ? HIGH : IDLE;
          end else if (rise) begin
            state <= HIGH;
          end
        end

        default: state <= WAIT_LATCH;
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_rx_decoder.sv
// Scoreboard bench for neopixel_rx_decoder: stimulus queues expected pixels and forwarded bits, a monitor compares them.
`timescale 1ns/1ps
module tb_neopixel_rx_decoder;
  import neopixel_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        led_data_in = 1'b0;
  logic        led_data_out;
  logic        pixel_valid;
  logic [31:0] pixel_data;
  logic [7:0]  pixel_index;
  logic        frame_latch;
  logic        error;

  always #10 clk = ~clk;

  neopixel_rx_decoder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .led_data_in (led_data_in),
    .led_data_out(led_data_out),
    .pixel_valid (pixel_valid),
    .pixel_data  (pixel_data),
    .pixel_index (pixel_index),
    .frame_latch (frame_latch),
    .error       (error)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  idx;
  } t_exp_pixel;

  t_exp_pixel px_q[$];
  logic       fwd_q[$];

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0, latch_cnt = 0, err_cnt = 0, both_cnt = 0, fwd_pulses = 0;
  int fwd_w = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pixel or finishes a forwarded pulse.
  always @(negedge clk) begin
    t_exp_pixel e;
    logic       exp_bit;
    if (!reset_n) begin
      fwd_w = 0;
    end else begin
      if (pixel_valid) begin
        valid_cnt++;
        if (px_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pixel_unexpected: got data 0x%0h index %0d with nothing expected", pixel_data, pixel_index);
        end else begin
          e = px_q.pop_front();
          check("pixel_data", {32'h0, pixel_data}, {32'h0, e.data});
          check("pixel_index", {56'h0, pixel_index}, {56'h0, e.idx});
        end
      end
      if (frame_latch) latch_cnt++;
      if (error) err_cnt++;
      if (frame_latch && error) both_cnt++;
      if (led_data_out) begin
        fwd_w++;
      end else if (fwd_w > 0) begin
        fwd_pulses++;
        if (fwd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fwd_unexpected: got pulse of %0d cycles with nothing expected", fwd_w);
        end else begin
          exp_bit = fwd_q.pop_front();
          check("fwd_bit", 64'(fwd_w >= 30), 64'(exp_bit));
        end
        fwd_w = 0;
      end
    end
  end

  task automatic idle_low(input int n);
    led_data_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Bit 1 = 40 high / 22 low, bit 0 = 20 high / 42 low.
  task automatic send_bit(input logic b, input bit fwd);
    if (fwd) fwd_q.push_back(b);
    led_data_in = 1'b1;
    repeat (b ? 40 : 20) @(negedge clk);
    led_data_in = 1'b0;
    repeat (b ? 22 : 42) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input bit fwd);
    for (int k = 0; k < n; k++) send_bit(v[BITS_PER_PIXEL-1-k], fwd);
  endtask

  // Words below keep [31:24] zero, so the expected pixel_data equals the word in either build.
  task automatic send_pixel(input logic [31:0] v, input bit expect_it, input logic [7:0] idx, input bit fwd);
    if (expect_it) px_q.push_back('{data: v, idx: idx});
    send_bits(v, BITS_PER_PIXEL, fwd);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({led_data_out, pixel_valid, frame_latch, error, pixel_index, pixel_data}), 64'h0);
    reset_n = 1'b1;
    idle_low(2600);
    check("no_latch_after_reset", 64'(latch_cnt), 64'd0);

    // Single pixel: decoded at index 0, nothing forwarded.
    send_pixel(32'h00FF0000, 1'b1, 8'd0, 1'b0);
    idle_low(2600);
    check("t1_valid_cnt", 64'(valid_cnt), 64'd1);
    check("t1_fwd_quiet", 64'(fwd_pulses), 64'd0);
    check("t1_latch_cnt", 64'(latch_cnt), 64'd1);

    // Three pixels: the downstream stream carries pixels 1 and 2 only.
    send_pixel(32'h00112233, 1'b1, 8'd0, 1'b0);
    send_pixel(32'h00445566, 1'b1, 8'd1, 1'b1);
    send_pixel(32'h00778899, 1'b1, 8'd2, 1'b1);
    idle_low(2600);
    check("t2_valid_cnt", 64'(valid_cnt), 64'd4);
    check("t2_latch_cnt", 64'(latch_cnt), 64'd2);
    check("t2_fwd_pulses", 64'(fwd_pulses), 64'(2 * BITS_PER_PIXEL));
    check("t2_err_cnt", 64'(err_cnt), 64'd0);

    // Latch after 10 bits: frame_latch and error together, then a clean frame from index 0.
    send_bits(32'h00A5A5A5, 10, 1'b0);
    idle_low(2600);
    check("t3_latch_cnt", 64'(latch_cnt), 64'd3);
    check("t3_latch_with_err", 64'(both_cnt), 64'd1);
    check("t3_err_cnt", 64'(err_cnt), 64'd1);
    check("t3_no_pixel", 64'(valid_cnt), 64'd4);
    send_pixel(32'h00A5C3E1, 1'b1, 8'd0, 1'b0);
    idle_low(2600);
    check("t3_recover", 64'(valid_cnt), 64'd5);

    // 5-cycle glitch mid-pixel: error, following bits ignored until a full gap.
    send_bits(32'h00F0F0F0, 8, 1'b0);
    led_data_in = 1'b1;
    repeat (5) @(negedge clk);
    idle_low(42);
    send_bits(32'h00FFFFFF, 4, 1'b0);
    idle_low(2600);
    check("t4_err_cnt", 64'(err_cnt), 64'd2);
    check("t4_no_pixel", 64'(valid_cnt), 64'd5);
    check("t4_no_latch", 64'(latch_cnt), 64'd4);
    send_pixel(32'h000000FF, 1'b1, 8'd0, 1'b0);
    idle_low(2600);
    check("t4_recover", 64'(valid_cnt), 64'd6);
    check("t4_latch_cnt", 64'(latch_cnt), 64'd5);

    // Line stuck high for 100 cycles: one error, no latch from the wait state.
    led_data_in = 1'b1;
    repeat (100) @(negedge clk);
    idle_low(2600);
    check("t5_err_once", 64'(err_cnt), 64'd3);
    check("t5_no_latch", 64'(latch_cnt), 64'd5);
    send_pixel(32'h00123456, 1'b1, 8'd0, 1'b0);
    idle_low(2600);
    check("t5_recover", 64'(valid_cnt), 64'd7);

    // Asynchronous reset in the middle of a forwarded pulse.
    send_pixel(32'h005A5A5A, 1'b1, 8'd0, 1'b0);
    send_bits(32'h00C3C3C3, 5, 1'b1);
    led_data_in = 1'b1;
    repeat (15) @(negedge clk);
    check("t6_fwd_mid_pulse", 64'(led_data_out), 64'd1);
    check("t6_index_before_reset", 64'(pixel_index), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_async_reset", 64'({led_data_out, pixel_valid, frame_latch, error, pixel_index, pixel_data}), 64'h0);
    led_data_in = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    idle_low(100);
    send_pixel(32'h00FFFFFF, 1'b0, 8'd0, 1'b0);
    idle_low(2600);
    check("t6_no_spurious_latch", 64'(latch_cnt), 64'd6);
    check("t6_ignored_pixel", 64'(valid_cnt), 64'd8);
    send_pixel(32'h000F1E2D, 1'b1, 8'd0, 1'b0);
    idle_low(2600);
    check("t6_recover", 64'(valid_cnt), 64'd9);
    check("t6_latch_cnt", 64'(latch_cnt), 64'd7);
    check("t6_fwd_pulses", 64'(fwd_pulses), 64'(2 * BITS_PER_PIXEL + 5));

    check("px_queue_empty", 64'(px_q.size()), 64'd0);
    check("fwd_queue_empty", 64'(fwd_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
